vending_machine_gen2: RTL and testbench

VENDING_MACHINE_GEN2 -- requirements
Module: vending_machine_gen2

---
 rtl/vending_pkg.sv | 33 +++
 rtl/vm_stock.sv | 54 +++++
 rtl/vending_machine_gen2.sv | 171 +++++++++++++++++
 tb/tb_vending_machine_gen2.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared types and helpers for the vending machine:
//   state_e      - FSM state encoding
//   COIN_1/2     - legal coin codes on coin_val
//   price_slice  - extracts one item price from a packed price vector
// ---------------------------------------------------------------------------
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    COLLECT,
    VEND,
    REFUND
  } state_e;

  localparam logic [1:0] COIN_1 = 2'd1;
  localparam logic [1:0] COIN_2 = 2'd2;

  // Price vectors are zero-extended to a fixed 256-bit carrier so one
  // function serves every N_ITEMS/CREDIT_W combination (up to 16 x 16).
  localparam int PRICE_VEC_W = 256;

  function automatic logic [15:0] price_slice(input logic [PRICE_VEC_W-1:0] prices,
                                              input int idx,
                                              input int w);
    logic [15:0] mask;
    mask = (16'd1 << w) - 16'd1;
    return 16'(prices >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/vm_stock.sv
// ---------------------------------------------------------------------------
// vm_stock
// Per-item stock counters with saturating restock and single-item decrement.
//   clk, rst                  - clock, asynchronous active-high reset
//   restock_vld/idx/qty       - add qty to item idx (saturates at all-ones)
//   dec_vld, dec_idx          - remove one unit of item dec_idx
//   sold_out[i]               - combinational, high when stock of item i is 0
// ---------------------------------------------------------------------------
module vm_stock #(
  parameter int N_ITEMS    = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  localparam int IDX_W     = $clog2(N_ITEMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restock_vld,
  input  logic [IDX_W-1:0]   restock_idx,
  input  logic [STOCK_W-1:0] restock_qty,
  input  logic               dec_vld,
  input  logic [IDX_W-1:0]   dec_idx,
  output logic [N_ITEMS-1:0] sold_out
);

  logic [STOCK_W-1:0] stock_q [N_ITEMS];
  logic [STOCK_W-1:0] stock_d [N_ITEMS];
  logic [STOCK_W:0]   sum     [N_ITEMS];

  // The decrement only ever hits an item that was checked non-empty, so the
  // one-bit-wider sum cannot underflow; its carry bit signals saturation.
  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      sum[i] = {1'b0, stock_q[i]}
             + ((restock_vld && restock_idx == IDX_W'(i)) ? {1'b0, restock_qty} : '0)
             - (STOCK_W+1)'(dec_vld && dec_idx == IDX_W'(i));
      stock_d[i] = sum[i][STOCK_W] ? '1 : sum[i][STOCK_W-1:0];
    end
  end

  // NOTE: this array is a handful of flops rather than a RAM, so every entry
  // is reset; a real memory macro would not be cleared this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
  end

endmodule

// File: rtl/vending_machine_gen2.sv
// ---------------------------------------------------------------------------
// vending_machine_gen2
// Coin-operated vending controller with per-item stock and timeout refund.
//   clk, rst                  - clock, asynchronous active-high reset
//   sel                       - one-hot item request (other values ignored)
//   coin_vld, coin_val        - coin strobe and value (1 or 2 legal)
//   cnl                       - cancel, refunds held credit
//   restock_vld/idx/qty       - restock interface, accepted in any state
//   pdt, pdt_idx, cng         - dispense pulse, item index, change
//   rtn_vld, rtn              - refund pulse and amount
//   coin_rej                  - previous cycle's coin was rejected
//   busy                      - FSM is not IDLE
//   sold_out                  - per-item empty flags (combinational)
// ---------------------------------------------------------------------------
module vending_machine_gen2 #(
  parameter int                            N_ITEMS     = 4,
  parameter int                            CREDIT_W    = 4,
  parameter logic [N_ITEMS*CREDIT_W-1:0]   PRICES      = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int                            STOCK_W     = 4,
  parameter int                            INIT_STOCK  = 5,
  parameter int                            TIMEOUT_CYC = 255,
  localparam int                           IDX_W       = $clog2(N_ITEMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_ITEMS-1:0]  sel,
  input  logic                coin_vld,
  input  logic [1:0]          coin_val,
  input  logic                cnl,
  input  logic                restock_vld,
  input  logic [IDX_W-1:0]    restock_idx,
  input  logic [STOCK_W-1:0]  restock_qty,
  output logic                pdt,
  output logic [IDX_W-1:0]    pdt_idx,
  output logic [CREDIT_W-1:0] cng,
  output logic [CREDIT_W-1:0] rtn,
  output logic                rtn_vld,
  output logic                coin_rej,
  output logic                busy,
  output logic [N_ITEMS-1:0]  sold_out
);

  import vending_pkg::*;

  localparam int                  TMO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [PRICE_VEC_W-1:0] PRICES_EXT = PRICE_VEC_W'(PRICES);

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q, pdt_idx_q, sel_idx;
  logic [CREDIT_W-1:0] credit_q, cng_q, rtn_q, price;
  logic [TMO_W-1:0]    tmo_q;
  logic                pdt_q, rtn_vld_q, coin_rej_q, busy_q;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_legal, coin_ok;

  // NOTE: a default before the loop keeps this purely combinational; without
  // it, a zero sel would hold the old value and infer a latch.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  assign price      = CREDIT_W'(price_slice(PRICES_EXT, int'(idx_q), CREDIT_W));
  assign coin_legal = (coin_val == COIN_1) || (coin_val == COIN_2);
  assign coin_sum   = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
  // Cancel outranks a simultaneous coin; the carry bit flags credit overflow.
  assign coin_ok    = coin_vld && coin_legal && !coin_sum[CREDIT_W] && !cnl;

  // NOTE: all state and output registers use non-blocking assignments so
  // every right-hand side sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      credit_q   <= '0;
      tmo_q      <= '0;
      pdt_q      <= 1'b0;
      pdt_idx_q  <= '0;
      cng_q      <= '0;
      rtn_q      <= '0;
      rtn_vld_q  <= 1'b0;
      coin_rej_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pdt_q      <= 1'b0;
      cng_q      <= '0;
      rtn_q      <= '0;
      rtn_vld_q  <= 1'b0;
      coin_rej_q <= coin_vld;  // any coin outside COLLECT is bounced
      case (state_q)
        IDLE: begin
          if ($onehot(sel)) begin
            idx_q   <= sel_idx;
            state_q <= CHECK;
            busy_q  <= 1'b1;
          end
        end
        CHECK: begin
          if (!sold_out[idx_q]) begin
            credit_q <= '0;
            tmo_q    <= '0;
            state_q  <= COLLECT;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        COLLECT: begin
          coin_rej_q <= coin_vld && !coin_ok;
          if (cnl) begin
            rtn_q     <= credit_q;
            rtn_vld_q <= 1'b1;
            state_q   <= REFUND;
          end else if (coin_ok) begin
            credit_q <= coin_sum[CREDIT_W-1:0];
            tmo_q    <= '0;
            if (coin_sum >= {1'b0, price}) begin
              pdt_q     <= 1'b1;
              pdt_idx_q <= idx_q;
              cng_q     <= CREDIT_W'(coin_sum - {1'b0, price});
              state_q   <= VEND;
            end
          end else if (tmo_q == TMO_LAST) begin
            // This idle cycle is the TIMEOUT_CYC-th in a row.
            rtn_q     <= credit_q;
            rtn_vld_q <= 1'b1;
            state_q   <= REFUND;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        VEND, REFUND: begin
          credit_q <= '0;
          state_q  <= IDLE;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  vm_stock #(
    .N_ITEMS   (N_ITEMS),
    .STOCK_W   (STOCK_W),
    .INIT_STOCK(INIT_STOCK)
  ) u_stock (
    .clk        (clk),
    .rst        (rst),
    .restock_vld(restock_vld),
    .restock_idx(restock_idx),
    .restock_qty(restock_qty),
    .dec_vld    (state_q == VEND),
    .dec_idx    (idx_q),
    .sold_out   (sold_out)
  );

  assign pdt      = pdt_q;
  assign pdt_idx  = pdt_idx_q;
  assign cng      = cng_q;
  assign rtn      = rtn_q;
  assign rtn_vld  = rtn_vld_q;
  assign coin_rej = coin_rej_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_vending_machine_gen2.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_gen2
// Directed bench for vending_machine_gen2 with default parameters
// (prices item0..3 = 3,4,5,6; stock 5 each; timeout 255 cycles).
// ---------------------------------------------------------------------------
module tb_vending_machine_gen2;

  logic       clk, rst;
  logic [3:0] sel;
  logic       coin_vld;
  logic [1:0] coin_val;
  logic       cnl;
  logic       restock_vld;
  logic [1:0] restock_idx;
  logic [3:0] restock_qty;
  logic       pdt;
  logic [1:0] pdt_idx;
  logic [3:0] cng, rtn;
  logic       rtn_vld, coin_rej, busy;
  logic [3:0] sold_out;

  int n_cmp  = 0;
  int n_fail = 0;

  vending_machine_gen2 dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .coin_vld   (coin_vld),
    .coin_val   (coin_val),
    .cnl        (cnl),
    .restock_vld(restock_vld),
    .restock_idx(restock_idx),
    .restock_qty(restock_qty),
    .pdt        (pdt),
    .pdt_idx    (pdt_idx),
    .cng        (cng),
    .rtn        (rtn),
    .rtn_vld    (rtn_vld),
    .coin_rej   (coin_rej),
    .busy       (busy),
    .sold_out   (sold_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0] sel;
    logic       cv;
    logic [1:0] val;
    logic       cnl;
    logic       pdt;
    logic [1:0] idx;
    logic [3:0] cng;
    logic       rv;
    logic [3:0] rtn;
    logic       rej;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] s, input logic cv, input logic [1:0] v,
                              input logic c, input logic p, input logic [1:0] pi,
                              input logic [3:0] cg, input logic rv, input logic [3:0] r,
                              input logic rej, input logic b);
    vec_t t;
    t.sel = s;  t.cv = cv; t.val = v;  t.cnl = c;
    t.pdt = p;  t.idx = pi; t.cng = cg; t.rv = rv; t.rtn = r;
    t.rej = rej; t.busy = b;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic cv, input logic [1:0] v, input logic c);
    sel = s; coin_vld = cv; coin_val = v; cnl = c;
    tick();
  endtask

  task automatic idle();
    drive(4'b0000, 1'b0, 2'd0, 1'b0);
  endtask

  logic early;

  initial begin
    rst = 1'b1;
    sel = '0; coin_vld = 1'b0; coin_val = '0; cnl = 1'b0;
    restock_vld = 1'b0; restock_idx = '0; restock_qty = '0;
    tick(); tick();

    // Reset state
    check("rst_pdt", pdt, 0);
    check("rst_rtn_vld", rtn_vld, 0);
    check("rst_coin_rej", coin_rej, 0);
    check("rst_busy", busy, 0);
    check("rst_sold_out", sold_out, 4'b0000);
    check("rst_stock0", dut.u_stock.stock_q[0], 5);
    rst = 1'b0;
    tick();

    // Per-cycle vectors: inputs | pdt idx cng rtn_vld rtn coin_rej busy
    // Item 0 (price 3), coins 2,2 -> change 1
    vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 1, 2, 0, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Item 3 (price 6), coins 2,2,2 -> exact
    vecs.push_back(mk(4'b1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 1, 2, 0, 1, 3, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Coin in IDLE is rejected
    vecs.push_back(mk(4'b0000, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    // Item 2: coin in CHECK rejected, coin 2, then cancel + coin 1
    vecs.push_back(mk(4'b0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(4'b0000, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 1, 1, 1, 0, 0, 0, 1, 2, 1, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Item 1: coin 1, illegal coins 3 and 0, cancel -> refund 1
    vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Non-one-hot selections are ignored
    vecs.push_back(mk(4'b0011, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sel, vecs[i].cv, vecs[i].val, vecs[i].cnl);
      check($sformatf("v%0d_pdt", i), pdt, vecs[i].pdt);
      if (vecs[i].pdt) check($sformatf("v%0d_pdt_idx", i), pdt_idx, vecs[i].idx);
      check($sformatf("v%0d_cng", i), cng, vecs[i].cng);
      check($sformatf("v%0d_rtn_vld", i), rtn_vld, vecs[i].rv);
      check($sformatf("v%0d_rtn", i), rtn, vecs[i].rtn);
      check($sformatf("v%0d_coin_rej", i), coin_rej, vecs[i].rej);
      check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
    end

    check("stock0_after_vend", dut.u_stock.stock_q[0], 4);
    check("stock3_after_vend", dut.u_stock.stock_q[3], 4);
    check("stock2_after_refund", dut.u_stock.stock_q[2], 5);

    // Drain item 3 (4 left), then a request for it must bounce back to IDLE
    for (int k = 0; k < 4; k++) begin
      drive(4'b1000, 1'b0, 2'd0, 1'b0);
      idle();
      drive(4'b0000, 1'b1, 2'd2, 1'b0);
      drive(4'b0000, 1'b1, 2'd2, 1'b0);
      drive(4'b0000, 1'b1, 2'd2, 1'b0);
      check($sformatf("drain%0d_pdt", k), pdt, 1);
      check($sformatf("drain%0d_idx", k), pdt_idx, 3);
      idle();
    end
    check("sold_out_item3", sold_out, 4'b1000);
    drive(4'b1000, 1'b0, 2'd0, 1'b0);
    check("soldout_check_busy", busy, 1);
    idle();
    check("soldout_back_idle", busy, 0);
    check("soldout_no_pdt0", pdt, 0);
    idle();
    check("soldout_no_pdt1", pdt, 0);

    // Timeout: item 1, coin 1, then 255 idle cycles
    drive(4'b0010, 1'b0, 2'd0, 1'b0);
    idle();
    drive(4'b0000, 1'b1, 2'd1, 1'b0);
    early = 1'b0;
    for (int k = 1; k < 255; k++) begin
      idle();
      early = early | rtn_vld | !busy;
    end
    check("tmo_no_early_refund", early, 0);
    idle();
    check("tmo_rtn_vld", rtn_vld, 1);
    check("tmo_rtn", rtn, 1);
    idle();
    check("tmo_idle_busy", busy, 0);
    check("tmo_rtn_vld_clear", rtn_vld, 0);

    // Restock item 0 back to 5, then restock 15 during its VEND cycle
    restock_vld = 1'b1; restock_idx = 2'd0; restock_qty = 4'd1;
    idle();
    restock_vld = 1'b0;
    check("restock_stock0", dut.u_stock.stock_q[0], 5);
    drive(4'b0001, 1'b0, 2'd0, 1'b0);
    idle();
    drive(4'b0000, 1'b1, 2'd2, 1'b0);
    drive(4'b0000, 1'b1, 2'd2, 1'b0);
    check("rv_pdt", pdt, 1);
    check("rv_cng", cng, 1);
    restock_vld = 1'b1; restock_idx = 2'd0; restock_qty = 4'd15;
    idle();
    restock_vld = 1'b0;
    check("restock_vend_sat", dut.u_stock.stock_q[0], 15);
    restock_vld = 1'b1; restock_idx = 2'd2; restock_qty = 4'd15;
    idle();
    restock_vld = 1'b0;
    check("restock_sat_item2", dut.u_stock.stock_q[2], 15);

    // Reset mid-transaction discards credit without a refund
    drive(4'b0100, 1'b0, 2'd0, 1'b0);
    idle();
    drive(4'b0000, 1'b1, 2'd2, 1'b0);
    sel = '0; coin_vld = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy_async", busy, 0);
    check("midrst_rtn_vld_async", rtn_vld, 0);
    tick();
    check("midrst_rtn_vld", rtn_vld, 0);
    check("midrst_stock0", dut.u_stock.stock_q[0], 5);
    check("midrst_sold_out", sold_out, 4'b0000);
    rst = 1'b0;
    drive(4'b0100, 1'b0, 2'd0, 1'b0);
    idle();
    drive(4'b0000, 1'b0, 2'd0, 1'b1);
    check("zero_refund_vld", rtn_vld, 1);
    check("zero_refund_amt", rtn, 0);
    idle();
    check("zero_refund_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
